// File: rtl/passcode_pkg.sv
// passcode_pkg
// Shared definitions for the passcode entry path: digit count, keypad
// control codes, the digit-entry state encoding and a key classifier.
// The downstream comparator imports NUM_DIGITS from here so both sides
// agree on the code length.
package passcode_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [3:0] KEY_BACKSPACE = 4'hA;
    localparam logic [3:0] KEY_CLEAR     = 4'hB;
    localparam logic [3:0] KEY_ENTER     = 4'hC;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        SUBMIT = 2'd2
    } entry_state_t;

    // Codes 0..C carry meaning; D..F are dropped without side effects.
    function automatic logic is_accepted_code(input logic [3:0] code);
        return (code <= KEY_ENTER);
    endfunction

    function automatic logic is_digit_code(input logic [3:0] code);
        return (code <= 4'h9);
    endfunction

endpackage

// File: rtl/idle_timer.sv
// idle_timer
// Counts idle cycles while run_i is high and flags when the count would
// reach TIMEOUT_CYCLES, so the owner can clear on that same edge.
// Ports:
//   clk_i    rising-edge clock
//   rst_i    synchronous active-high reset
//   run_i    count enable (entry in progress)
//   kick_i   restart from zero (an accepted key)
//   expire_o one-cycle pulse, high in the cycle whose closing edge is the
//            TIMEOUT_CYCLES-th idle edge
module idle_timer #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    input  logic kick_i,
    output logic expire_o
);
    import passcode_pkg::*;

    localparam int              CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Expiry is decoded from the registered count so the owner's registered
    // clear lands exactly TIMEOUT_CYCLES edges after the last kick; a kick in
    // the same cycle wins over the timeout.
    assign expire_o = run_i & ~kick_i & (cnt_q == LAST);

    // Next count: hold at zero when not running, restart on kick or expiry.
    always_comb begin
        cnt_d = cnt_q;
        if (!run_i || kick_i || expire_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/digit_entry.sv
// digit_entry
// Keypad digit-entry buffer feeding the passcode comparator. Collects up
// to four BCD digits in entry order with backspace, clear, enter and an
// idle timeout, and presents a completed code with a submit pulse.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   key_valid_i/key_code_i one-cycle key strobe and its code
//   bcd_0_o..bcd_3_o       digits in entry order, unentered read 0
//   count_o                digits held (0..4)
//   full_o                 count_o == 4
//   submit_o               one-cycle pulse, code valid for the comparator
//   error_o                one-cycle pulse on enter with a short code
module digit_entry #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       key_valid_i,
    input  logic [3:0] key_code_i,
    output logic [3:0] bcd_0_o,
    output logic [3:0] bcd_1_o,
    output logic [3:0] bcd_2_o,
    output logic [3:0] bcd_3_o,
    output logic [2:0] count_o,
    output logic       full_o,
    output logic       submit_o,
    output logic       error_o
);
    import passcode_pkg::*;

    entry_state_t state_q;
    entry_state_t state_d;
    logic [3:0]   digits_q [NUM_DIGITS];
    logic [3:0]   digits_d [NUM_DIGITS];
    logic [2:0]   count_q;
    logic [2:0]   count_d;
    logic         full_q;
    logic         full_d;
    logic         submit_q;
    logic         submit_d;
    logic         error_q;
    logic         error_d;

    logic         key_accepted;
    logic         timer_kick;
    logic         timer_run;
    logic         timer_expire;
    logic [2:0]   last_idx;

    // Keys arriving in the SUBMIT cycle are dropped, so they neither act nor
    // restart the timer.
    assign key_accepted = key_valid_i & is_accepted_code(key_code_i);
    assign timer_kick   = key_accepted & (state_q != SUBMIT);
    assign timer_run    = (state_q == ENTRY);
    assign last_idx     = count_q - 3'd1;

    idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .run_i    (timer_run),
        .kick_i   (timer_kick),
        .expire_o (timer_expire)
    );

    // Next-state, digit file and pulse logic; key strobe outranks timeout.
    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        count_d  = count_q;
        submit_d = 1'b0;
        error_d  = 1'b0;

        case (state_q)
            SUBMIT: begin
                digits_d = '{default: 4'h0};
                count_d  = 3'd0;
                state_d  = IDLE;
            end
            IDLE, ENTRY: begin
                if (key_accepted) begin
                    if (is_digit_code(key_code_i)) begin
                        if (count_q < 3'(NUM_DIGITS)) begin
                            digits_d[count_q[1:0]] = key_code_i;
                            count_d = count_q + 3'd1;
                            state_d = ENTRY;
                        end else begin
                            // Full: the key only restarts the idle timer.
                            count_d = count_q;
                        end
                    end else begin
                        case (key_code_i)
                            KEY_BACKSPACE: begin
                                if (count_q != 3'd0) begin
                                    digits_d[last_idx[1:0]] = 4'h0;
                                    count_d = last_idx;
                                    state_d = (last_idx == 3'd0) ? IDLE : ENTRY;
                                end else begin
                                    count_d = count_q;
                                end
                            end
                            KEY_CLEAR: begin
                                digits_d = '{default: 4'h0};
                                count_d  = 3'd0;
                                state_d  = IDLE;
                            end
                            KEY_ENTER: begin
                                if (count_q == 3'(NUM_DIGITS)) begin
                                    submit_d = 1'b1;
                                    state_d  = SUBMIT;
                                end else begin
                                    // Short code is discarded in the same edge
                                    // that raises the error pulse.
                                    error_d  = 1'b1;
                                    digits_d = '{default: 4'h0};
                                    count_d  = 3'd0;
                                    state_d  = IDLE;
                                end
                            end
                            default: begin
                                state_d = state_q;
                            end
                        endcase
                    end
                end else if (timer_expire) begin
                    digits_d = '{default: 4'h0};
                    count_d  = 3'd0;
                    state_d  = IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                digits_d = '{default: 4'h0};
                count_d  = 3'd0;
                state_d  = IDLE;
            end
        endcase

        full_d = (count_d == 3'(NUM_DIGITS));
    end

    // State, digit file and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            digits_q <= '{default: 4'h0};
            count_q  <= 3'd0;
            full_q   <= 1'b0;
            submit_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            count_q  <= count_d;
            full_q   <= full_d;
            submit_q <= submit_d;
            error_q  <= error_d;
        end
    end

    assign bcd_0_o  = digits_q[0];
    assign bcd_1_o  = digits_q[1];
    assign bcd_2_o  = digits_q[2];
    assign bcd_3_o  = digits_q[3];
    assign count_o  = count_q;
    assign full_o   = full_q;
    assign submit_o = submit_q;
    assign error_o  = error_q;

endmodule
